// File: rtl/config_bitstream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : config_bitstream_loader                                         |
// | Purpose  : Serialises bitstream words MSB-first into the fabric config     |
// |            shift register. Define CONFIG_LOADER_CRC_EN for a CRC-16 check. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module config_bitstream_loader #(
    parameter int WORD_WIDTH  = 32,
    parameter int CONFIG_BITS = 34688
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_error
);

    localparam int c_CNT_W = $clog2(CONFIG_BITS + 1);
    localparam int c_IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_COUNT = c_CNT_W'(CONFIG_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(WORD_WIDTH - 1);

`ifdef CONFIG_LOADER_CRC_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;
    localparam logic [15:0] c_CRC_POLY = 16'h1021;
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t                r_state, w_state_next;
    logic [WORD_WIDTH-1:0] r_shreg, w_shreg_next;
    logic [c_IDX_W-1:0]    r_bit_idx, w_bit_idx_next;
    logic [c_CNT_W-1:0]    r_bit_count, w_bit_count_next, w_count_inc;
    logic                  r_word_ready, r_config_data, r_config_enable, r_busy, r_done;
    logic                  w_word_ready_next, w_config_data_next, w_busy_next, w_done_next;
    logic                  w_handshake;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] r_crc, w_crc_next, w_crc_step;
    logic        r_crc_error, w_crc_error_next;
    logic        w_crc_fb;

    // The bit on config_data this cycle is the one the shift register takes at the edge.
    always_comb begin
        w_crc_fb   = r_crc[15] ^ r_config_data;
        w_crc_step = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? c_CRC_POLY : 16'h0000);
    end
`endif

    always_comb begin
        w_state_next       = r_state;
        w_shreg_next       = r_shreg;
        w_bit_idx_next     = r_bit_idx;
        w_bit_count_next   = r_bit_count;
        w_config_data_next = 1'b0;
        w_busy_next        = r_busy;
        w_done_next        = r_done;
        w_count_inc        = r_bit_count + 1'b1;
        w_handshake        = word_valid && r_word_ready;
`ifdef CONFIG_LOADER_CRC_EN
        w_crc_next         = r_crc;
        w_crc_error_next   = r_crc_error;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next     = S_FETCH;
                    w_bit_count_next = '0;
                    w_busy_next      = 1'b1;
                    w_done_next      = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
                    w_crc_next       = c_CRC_INIT;
                    w_crc_error_next = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b0;
                end else if (w_handshake) begin
                    // MSB goes straight to the output register; the rest queue up in shreg.
                    w_state_next       = S_SHIFT;
                    w_config_data_next = word_data[WORD_WIDTH-1];
                    w_shreg_next       = word_data << 1;
                    w_bit_idx_next     = '0;
                end
            end
            S_SHIFT: begin
                w_bit_count_next = w_count_inc;
                w_bit_idx_next   = r_bit_idx + 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                w_crc_next       = w_crc_step;
`endif
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b0;
                end else if (w_count_inc == c_LAST_COUNT) begin
`ifdef CONFIG_LOADER_CRC_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_DONE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
`endif
                end else if (r_bit_idx == c_LAST_IDX) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_config_data_next = r_shreg[WORD_WIDTH-1];
                    w_shreg_next       = r_shreg << 1;
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            S_CHECK: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b0;
                end else if (w_handshake) begin
                    w_state_next     = S_DONE;
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                    w_crc_error_next = (word_data[15:0] != r_crc);
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
                w_done_next  = 1'b0;
            end
        endcase

        w_word_ready_next = (w_state_next == S_FETCH);
`ifdef CONFIG_LOADER_CRC_EN
        w_word_ready_next = w_word_ready_next || (w_state_next == S_CHECK);
`endif
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state         <= S_IDLE;
            r_shreg         <= '0;
            r_bit_idx       <= '0;
            r_bit_count     <= '0;
            r_word_ready    <= 1'b0;
            r_config_data   <= 1'b0;
            r_config_enable <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_shreg         <= w_shreg_next;
            r_bit_idx       <= w_bit_idx_next;
            r_bit_count     <= w_bit_count_next;
            r_word_ready    <= w_word_ready_next;
            r_config_data   <= w_config_data_next;
            r_config_enable <= (w_state_next == S_SHIFT);
            r_busy          <= w_busy_next;
            r_done          <= w_done_next;
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_crc       <= c_CRC_INIT;
            r_crc_error <= 1'b0;
        end else begin
            r_crc       <= w_crc_next;
            r_crc_error <= w_crc_error_next;
        end
    end

    assign crc_error = r_crc_error;
`else
    assign crc_error = 1'b0;
`endif

    assign word_ready    = r_word_ready;
    assign config_data   = r_config_data;
    assign config_enable = r_config_enable;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_config_bitstream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_config_bitstream_loader                                      |
// | Purpose  : Self-checking bench for config_bitstream_loader with a serial   |
// |            shift-register model and a bit-level scoreboard.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module tb_config_bitstream_loader;

`ifdef CONFIG_LOADER_CRC_EN
    localparam int W = 16;
    localparam int N = 32;
`else
    localparam int W = 8;
    localparam int N = 20;
`endif

    logic         clock      = 1'b0;
    logic         nreset     = 1'b0;
    logic         start      = 1'b0;
    logic         abort      = 1'b0;
    logic         word_valid = 1'b0;
    logic [W-1:0] word_data  = '0;
    logic         word_ready, config_data, config_enable, busy, done, crc_error;

    config_bitstream_loader #(
        .WORD_WIDTH (W),
        .CONFIG_BITS(N)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .start        (start),
        .abort        (abort),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .config_data  (config_data),
        .config_enable(config_enable),
        .busy         (busy),
        .done         (done),
        .crc_error    (crc_error)
    );

    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] feed_q[$];
    logic         exp_q[$];
    logic [N-1:0] sr_model = '0;
    logic [15:0]  crc_model = 16'hFFFF;
    int           shift_count, stall_cycles, words_taken, bits_left, latency;
    int           stall_idx = -1;
    int           stall_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the shift register at the falling edge, then update the word feeder.
    task automatic tick();
        logic hs;
        logic e;
        @(negedge clock);
        if (config_enable) begin
            check("shift_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("serial_bit", 32'(config_data), 32'(e));
            end
            sr_model = {sr_model[N-2:0], config_data};
            shift_count++;
        end
        if (word_ready && !word_valid && !config_enable) stall_cycles++;
        hs = word_valid && word_ready && !abort && nreset;
        @(posedge clock);
        #1;
        if (hs) begin
            void'(feed_q.pop_front());
            words_taken++;
        end
        if (feed_q.size() == 0) begin
            word_valid = 1'b0;
        end else if (words_taken == stall_idx && stall_left > 0) begin
            word_valid = 1'b0;
            if (word_ready) stall_left--;
        end else begin
            word_valid = 1'b1;
            word_data  = feed_q[0];
        end
    endtask

    task automatic prep_load(input int s_idx, input int s_len);
        feed_q.delete();
        exp_q.delete();
        shift_count  = 0;
        stall_cycles = 0;
        words_taken  = 0;
        bits_left    = N;
        stall_idx    = s_idx;
        stall_left   = s_len;
        crc_model    = 16'hFFFF;
    endtask

    // Only the first N bits of the stream reach the shift register.
    task automatic push_word(input logic [W-1:0] w);
        logic fb;
        feed_q.push_back(w);
        for (int i = W - 1; i >= 0; i--) begin
            if (bits_left > 0) begin
                exp_q.push_back(w[i]);
                fb        = crc_model[15] ^ w[i];
                crc_model = {crc_model[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                bits_left--;
            end
        end
    endtask

    task automatic run_load(input int mid_start, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 500) begin
            start = (lat == mid_start);
            tick();
            lat++;
        end
        start = 1'b0;
        check("load_completes", 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("reset_outputs", 32'({word_ready, config_data, config_enable, busy, done, crc_error}), 0);
        nreset = 1'b1;
        tick();

`ifdef CONFIG_LOADER_CRC_EN
        prep_load(-1, 0);
        push_word(16'h1234);
        push_word(16'h5678);
        feed_q.push_back(W'(crc_model));
        run_load(-1, latency);
        check("crc_good_err", 32'(crc_error), 0);
        check("crc_good_done", 32'(done), 1);
        check("crc_good_sr", 32'(sr_model), 32'h12345678);
        check("crc_good_bits", shift_count, N);
        check("crc_trailer_taken", feed_q.size(), 0);

        prep_load(-1, 0);
        push_word(16'h1234);
        push_word(16'h5678);
        feed_q.push_back(W'(crc_model ^ 16'h0001));
        run_load(-1, latency);
        check("crc_bad_err", 32'(crc_error), 1);
        check("crc_bad_done", 32'(done), 1);
        check("crc_bad_busy", 32'(busy), 0);
`else
        // Basic load: three (FETCH + 8 SHIFT) groups, last trimmed to 4 bits -> 3 + 20 cycles.
        prep_load(-1, 0);
        push_word(8'hA5); push_word(8'h3C); push_word(8'hF0);
        run_load(-1, latency);
        check("basic_latency", latency, 23);
        check("basic_bits", shift_count, 20);
        check("basic_sr", 32'(sr_model), 32'h000A53CF);
        check("basic_busy", 32'(busy), 0);
        check("basic_ready", 32'(word_ready), 0);
        check("basic_stall", stall_cycles, 0);
        check("basic_scoreboard_empty", exp_q.size(), 0);
        check("basic_words_used", feed_q.size(), 0);
        check("basic_crc_error", 32'(crc_error), 0);

        // Stall before word 2, started straight from DONE.
        prep_load(1, 5);
        push_word(8'hA5); push_word(8'h3C); push_word(8'hF0);
        run_load(-1, latency);
        check("stall_cycles", stall_cycles, 5);
        check("stall_latency", latency, 28);
        check("stall_bits", shift_count, 20);
        check("stall_sr", 32'(sr_model), 32'h000A53CF);

        // Abort while the 11th bit (word 2, bit index 2) is on the wire.
        prep_load(-1, 0);
        push_word(8'hA5); push_word(8'h3C); push_word(8'hF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && !(shift_count == 10 && config_enable); k++) tick();
        check("abort_point", shift_count, 10);
        check("abort_point_enable", 32'(config_enable), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'({word_ready, config_enable, busy, done}), 0);
        tick();
        tick();
        check("abort_bits", shift_count, 11);
        check("abort_sr", 32'(sr_model[10:0]), 32'h529);
        check("abort_unsent", exp_q.size(), 9);
        check("abort_word3_kept", feed_q.size(), 1);

        // Reset pulse mid-shift, then a clean load.
        prep_load(-1, 0);
        push_word(8'hA5); push_word(8'h3C); push_word(8'hF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && !(shift_count == 5 && config_enable); k++) tick();
        check("reset_point", shift_count, 5);
        nreset = 1'b0;
        tick();
        check("midreset_outputs", 32'({word_ready, config_data, config_enable, busy, done, crc_error}), 0);
        nreset = 1'b1;
        tick();
        prep_load(-1, 0);
        push_word(8'hA5); push_word(8'h3C); push_word(8'hF0);
        run_load(-1, latency);
        check("postreset_sr", 32'(sr_model), 32'h000A53CF);
        check("postreset_bits", shift_count, 20);

        // Back-to-back zero load with a start pulse while busy.
        prep_load(-1, 0);
        push_word(8'h00); push_word(8'h00); push_word(8'h00);
        run_load(10, latency);
        check("b2b_sr", 32'(sr_model), 0);
        check("b2b_latency", latency, 23);
        check("b2b_bits", shift_count, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_in_done", 32'({busy, done}), 32'b01);
        check("idle_no_shift", shift_count, 20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
